// File: rtl/jam_pkg.sv
// Shared definitions for the JAM worker/job cost table: sizes, FSM state
// encoding, and address/parity helpers.
// Optional build macro: COST_PARITY_EN (even-parity check on loaded entries).
package jam_pkg;

  localparam int N      = 8;
  localparam int IDX_W  = 3;
  localparam int COST_W = 7;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = N * N;
  localparam int PTR_W  = 2 * IDX_W;

  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_LAST = {PTR_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [COST_W-1:0] COST_ZERO = {COST_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2,
    DONE  = 2'd3
  } jam_state_e;

  // Row-major table index w*N+j; N is a power of two so this is a concatenation.
  function automatic logic [PTR_W-1:0] idx(input logic [IDX_W-1:0] w,
                                           input logic [IDX_W-1:0] j);
    idx = {w, j};
  endfunction

  // Even-parity bit for a cost entry (makes the total count of ones even).
  function automatic logic even_par(input logic [COST_W-1:0] d);
    even_par = ^d;
  endfunction

endpackage

// File: rtl/jam_cost_table_if.sv
// Loader and engine signals of the JAM cost table grouped in one bundle.
// The table is the slave; the host loader / search engine side is the master.
// Optional build macro: COST_PARITY_EN adds load_par and par_err.
interface jam_cost_table_if;
  import jam_pkg::*;

  logic              load_valid;
  logic [COST_W-1:0] load_data;
  logic              load_ready;
  logic              reload;
  logic [IDX_W-1:0]  W;
  logic [IDX_W-1:0]  J;
  logic [COST_W-1:0] Cost;
  logic              Valid;
  logic              table_ready;
  logic              done;
  logic [CNT_W-1:0]  rd_count;
`ifdef COST_PARITY_EN
  logic              load_par;
  logic              par_err;

  modport slave (
    input  load_valid, load_data, load_par, reload, W, J, Valid,
    output load_ready, Cost, table_ready, done, rd_count, par_err
  );
  modport master (
    output load_valid, load_data, load_par, reload, W, J, Valid,
    input  load_ready, Cost, table_ready, done, rd_count, par_err
  );
`else
  modport slave (
    input  load_valid, load_data, reload, W, J, Valid,
    output load_ready, Cost, table_ready, done, rd_count
  );
  modport master (
    output load_valid, load_data, reload, W, J, Valid,
    input  load_ready, Cost, table_ready, done, rd_count
  );
`endif

endinterface

// File: rtl/jam_cost_mem.sv
// N*N x COST_W cost storage: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset; the FSM guarantees a full
// reload before any read is served.
module jam_cost_mem
  import jam_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [COST_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [COST_W-1:0] rdata
);

  logic [COST_W-1:0] mem_q [DEPTH];

  // Write one entry per accepted load beat.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/jam_cost_table.sv
// JAM cost table responder: serially loads the 8x8 worker/job cost matrix
// over a valid/ready port, then answers (W,J) lookups combinationally until
// the search engine signals completion or a reload is requested.
// Optional build macro: COST_PARITY_EN (sticky even-parity error on loads).
module jam_cost_table
  import jam_pkg::*;
(
  input logic             CLK,
  input logic             RST,
  jam_cost_table_if.slave bus
);

  jam_state_e        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d;
  logic              accept;
  logic [PTR_W-1:0]  rd_addr;
  logic [COST_W-1:0] rd_data;

  // Load beat handshake; a reload in the same cycle drops the beat.
  always_comb begin
    accept  = (state_q == LOAD) && bus.load_valid && !bus.reload;
    rd_addr = idx(bus.W, bus.J);
  end

  jam_cost_mem u_mem (
    .clk   (CLK),
    .we    (accept),
    .waddr (ptr_q),
    .wdata (bus.load_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // State, load pointer and serve-cycle counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_ZERO;
      rd_count_q <= CNT_ZERO;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_count_q <= rd_count_d;
    end
  end

  // Next-state logic; reload overrides everything, including Valid.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rd_count_d = rd_count_q;
    if (bus.reload) begin
      state_d    = LOAD;
      ptr_d      = PTR_ZERO;
      rd_count_d = CNT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = LOAD;
          ptr_d   = PTR_ZERO;
        end
        LOAD: begin
          if (accept) begin
            if (ptr_q == PTR_LAST) begin
              state_d = SERVE;
              ptr_d   = PTR_ZERO;
            end else begin
              ptr_d = ptr_q + PTR_ONE;
            end
          end else begin
            ptr_d = ptr_q;
          end
        end
        SERVE: begin
          if (rd_count_q == CNT_MAX) begin
            rd_count_d = rd_count_q;
          end else begin
            rd_count_d = rd_count_q + CNT_ONE;
          end
          if (bus.Valid) begin
            state_d = DONE;
          end else begin
            state_d = SERVE;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
          ptr_d   = PTR_ZERO;
        end
      endcase
    end
  end

  // Outputs decoded from the registered state; Cost is zero unless serving.
  always_comb begin
    bus.load_ready  = 1'b0;
    bus.table_ready = 1'b0;
    bus.done        = 1'b0;
    bus.Cost        = COST_ZERO;
    bus.rd_count    = rd_count_q;
    case (state_q)
      LOAD: begin
        bus.load_ready = 1'b1;
      end
      SERVE: begin
        bus.table_ready = 1'b1;
        bus.Cost        = rd_data;
      end
      DONE: begin
        bus.table_ready = 1'b1;
        bus.done        = 1'b1;
        bus.Cost        = rd_data;
      end
      default: begin
        bus.load_ready = 1'b0;
      end
    endcase
  end

`ifdef COST_PARITY_EN
  logic par_err_q, par_err_d;

  // Sticky parity error: set by any accepted entry with bad parity.
  always_comb begin
    par_err_d = par_err_q;
    if (bus.reload) begin
      par_err_d = 1'b0;
    end else if (accept && (bus.load_par != even_par(bus.load_data))) begin
      par_err_d = 1'b1;
    end else begin
      par_err_d = par_err_q;
    end
  end

  // Parity error flag register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign bus.par_err = par_err_q;
`endif

endmodule

// File: doc/jam_cost_table.md
Name: jam_cost_table

Overview:
- Responder end of the JAM worker/job cost interface: holds the 8x8 worker-by-job cost matrix and returns Cost for the (W,J) address that the assignment search engine drives each cycle.
- Matrix is loaded serially through a valid/ready port.
- After loading, the block serves zero-latency reads until the engine raises Valid (search done) or a reload is requested.
- Sits between the testbench/host loader and the JAM search engine.

Parameters:
- N, 8, workers = jobs; table depth N*N.
- IDX_W, 3, width of W/J indices (log2 N).
- COST_W, 7, cost entry width.
- CNT_W, 16, width of read-access counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- load_valid  in  1  loader presents an entry.
- load_data  in  COST_W  cost entry, row-major order (index = W*N+J).
- load_ready  out  1  block accepts an entry this cycle.
- reload  in  1  single-cycle pulse: discard table, restart loading.
- W  in  IDX_W  worker index from engine.
- J  in  IDX_W  job index from engine.
- Cost  out  COST_W  table[W][J].
- Valid  in  1  engine done flag.
- table_ready  out  1  table complete, serving reads.
- done  out  1  engine reported Valid while serving.
- rd_count  out  CNT_W  cycles spent in SERVE (saturating).

Behaviour:
- Reset values: load_ready=0, table_ready=0, done=0, rd_count=0, Cost=0. State=IDLE, load pointer=0. Table contents are not reset.
- FSM states: IDLE, LOAD, SERVE, DONE.
- IDLE -> LOAD unconditionally on the first clock after reset deasserts.
- LOAD:
  - load_ready=1.
  - An entry is accepted when load_valid && load_ready; it is written to table[ptr] and ptr increments.
  - Acceptance of entry N*N-1 -> SERVE on the next edge.
  - ptr is IDX_W*2 bits wide; it never wraps inside LOAD.
- SERVE:
  - table_ready=1, load_ready=0.
  - Cost = table[W*N+J], combinational from the registered array, so it is valid in the same cycle W/J are presented.
  - rd_count increments each cycle and saturates at all-ones.
  - Valid=1 -> DONE.
- DONE:
  - done=1, table_ready=1, Cost keeps tracking W/J.
  - rd_count frozen.
  - Held until reload or reset.
- Outside SERVE/DONE, Cost=0.
- reload in any state:
  - Next state LOAD; ptr=0, table_ready=0, done=0, rd_count=0.
  - reload takes priority over load acceptance in the same cycle (that entry is dropped) and over Valid.
- load_valid outside LOAD is ignored.
- Valid outside SERVE is ignored.
- RST asserted mid-load: the partial table is abandoned and loading restarts from index 0 after deassertion.

Optional Feature:
- Macro COST_PARITY_EN.
- When defined:
  - Extra input load_par (1 bit, even parity over load_data) and output par_err (1 bit, sticky).
  - Each accepted entry's parity is checked.
  - A mismatch sets par_err on the next edge; the entry is still stored.
  - par_err is cleared only by RST or reload.
- When undefined: load_par and par_err do not exist and no check logic is built.

Decomposition:
- Shared package jam_pkg: N, IDX_W, COST_W, the state enum (IDLE/LOAD/SERVE/DONE), and a function idx(w,j)=w*N+j.
- One natural sub-module: jam_cost_mem, the N*N x COST_W register array with one synchronous write port and one asynchronous read port.

Test Plan:
- Reset, then load entries 0..63 with data=(idx%100)+1 and load_valid held high -> 64 accepts, load_ready drops, table_ready=1 exactly one cycle after the last accept; W=3,J=5 gives Cost=30.
- Loader stalls: load_valid toggled every other cycle -> exactly 64 accepts; all 64 (W,J) reads match the loaded values.
- Drive W/J sweep in SERVE, then assert Valid -> done=1 next cycle; rd_count frozen at the number of SERVE cycles (e.g. 20); Cost still follows W/J.
- reload asserted in the same cycle as an accept of entry 10 -> entry dropped; state LOAD, ptr=0, done=0, rd_count=0; a reload of all 64 entries with value 7 reads back 7 everywhere.
- RST pulsed asynchronously (between edges) after 30 entries -> outputs clear immediately; 64 further entries are required before table_ready.
- With COST_PARITY_EN: entry 5 loaded with a wrong load_par -> par_err=1 next cycle and stays 1; Cost at (0,5) still equals the stored data; reload clears par_err.
